// File: rtl/ps2_host_tx.sv
// Purpose: host-to-device PS/2 transmitter; sends one command byte over open-drain PS2_CLK/PS2_DAT.
// Latency: INHIBIT_CYCLES+1 cycles of clock inhibit, then device-paced; data drive follows a pin fall by 3 cycles.
// Backpressure: send is taken only in IDLE outside the done cycle; requests while busy are dropped.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       send,
  input  logic [7:0] cmd_byte,
  output logic       busy,
  output logic       done,
  output logic       error,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES) + 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    START,
    SHIFT,
    ACK,
    WAIT_IDLE
  } state_t;

  state_t           state, state_nx;
  logic [1:0]       clk_sync, dat_sync;
  logic             clk_prev;
  logic             clk_s, dat_s, fall, timed;
  logic [8:0]       shreg, shreg_nx;
  logic [3:0]       edge_cnt, edge_nx;
  logic [INH_W-1:0] inh_cnt, inh_nx;
  logic [TO_W-1:0]  to_cnt, to_nx;
  logic             nack, nack_nx;
  logic             clk_oe_nx, dat_oe_nx, busy_nx, done_nx, error_nx;

  assign clk_s = clk_sync[1];
  assign dat_s = dat_sync[1];
  assign fall  = clk_prev & ~clk_s;
  assign timed = (state == SHIFT) || (state == ACK) || (state == WAIT_IDLE);

  // Two-flop synchronisers plus the previous synced clock for fall detection; idle bus reads high.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk_in};
      dat_sync <= {dat_sync[0], ps2_dat_in};
      clk_prev <= clk_s;
    end
  end

  // FSM state register.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state, counters, shift register and next values of the registered outputs.
  always_comb begin
    state_nx  = state;
    shreg_nx  = shreg;
    edge_nx   = edge_cnt;
    inh_nx    = inh_cnt;
    to_nx     = to_cnt;
    nack_nx   = nack;
    clk_oe_nx = ps2_clk_oe;
    dat_oe_nx = ps2_dat_oe;
    busy_nx   = busy;
    done_nx   = 1'b0;
    error_nx  = 1'b0;
    if (timed) to_nx = to_cnt + 1'b1;
    case (state)
      IDLE: begin
        clk_oe_nx = 1'b0;
        dat_oe_nx = 1'b0;
        busy_nx   = 1'b0;
        // The done register being high means the previous transfer is still finishing.
        if (send && !done) begin
          shreg_nx  = {~^cmd_byte, cmd_byte};
          edge_nx   = '0;
          inh_nx    = '0;
          to_nx     = '0;
          nack_nx   = 1'b0;
          busy_nx   = 1'b1;
          clk_oe_nx = 1'b1;
          state_nx  = INHIBIT;
        end
      end
      INHIBIT: begin
        inh_nx = inh_cnt + 1'b1;
        if (inh_cnt == INH_LAST) begin
          dat_oe_nx = 1'b1;
          state_nx  = START;
        end
      end
      START: begin
        // Release the clock; the start bit stays driven until the first device fall.
        clk_oe_nx = 1'b0;
        to_nx     = '0;
        state_nx  = SHIFT;
      end
      SHIFT: begin
        if (fall) begin
          edge_nx = edge_cnt + 4'd1;
          if (edge_cnt == 4'd9) begin
            dat_oe_nx = 1'b0;
            state_nx  = ACK;
          end else begin
            dat_oe_nx = ~shreg[0];
            shreg_nx  = {1'b0, shreg[8:1]};
          end
        end
      end
      ACK: begin
        if (fall) begin
          edge_nx  = edge_cnt + 4'd1;
          nack_nx  = dat_s;
          state_nx = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (clk_s && dat_s) begin
          done_nx  = 1'b1;
          error_nx = nack;
          busy_nx  = 1'b0;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
    // A stalled device aborts the transfer regardless of phase.
    if (timed && (to_cnt == TO_LAST)) begin
      clk_oe_nx = 1'b0;
      dat_oe_nx = 1'b0;
      busy_nx   = 1'b0;
      done_nx   = 1'b1;
      error_nx  = 1'b1;
      state_nx  = IDLE;
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      shreg      <= '0;
      edge_cnt   <= '0;
      inh_cnt    <= '0;
      to_cnt     <= '0;
      nack       <= 1'b0;
      ps2_clk_oe <= 1'b0;
      ps2_dat_oe <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      shreg      <= shreg_nx;
      edge_cnt   <= edge_nx;
      inh_cnt    <= inh_nx;
      to_cnt     <= to_nx;
      nack       <= nack_nx;
      ps2_clk_oe <= clk_oe_nx;
      ps2_dat_oe <= dat_oe_nx;
      busy       <= busy_nx;
      done       <= done_nx;
      error      <= error_nx;
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus with a PS/2 device model, expected frame bits and error flags queued at send time.
// Timing: 10 ns clock, device half-period of HALF cycles.
// Checks: frame bits as seen by the device, inhibit length, done/error pulses, timeout, reset and busy behaviour.
module tb_ps2_host_tx;

  localparam int INH  = 20;
  localparam int TO   = 2000;
  localparam int HALF = 50;

  logic       CLOCK_50 = 1'b0;
  logic       rst = 1'b0;
  logic       send = 1'b0;
  logic [7:0] cmd_byte = 8'h00;
  logic       busy, done, error;
  logic       ps2_clk_in, ps2_dat_in, ps2_clk_oe, ps2_dat_oe;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;

  int errors = 0;
  int checks = 0;
  int done_total = 0;

  bit exp_bits[$];
  bit got_bits[$];
  bit exp_err[$];

  assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .CLOCK_50  (CLOCK_50),
    .reset     (rst),
    .send      (send),
    .cmd_byte  (cmd_byte),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .ps2_clk_in(ps2_clk_in),
    .ps2_dat_in(ps2_dat_in),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_dat_oe(ps2_dat_oe)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  always @(negedge CLOCK_50) if (done === 1'b1) done_total++;

  initial begin
    #600us;
    $display("FAIL watchdog: simulation still running, got no end expected end");
    $fatal(1, "watchdog");
  end

  // Expected frame as the device should sample it: start, LSB-first data, odd parity, stop.
  task automatic push_frame(input logic [7:0] b);
    int ones = 0;
    exp_bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) begin
      exp_bits.push_back(b[i]);
      if (b[i]) ones++;
    end
    exp_bits.push_back((ones % 2) == 0);
    exp_bits.push_back(1'b1);
  endtask

  task automatic do_send(input logic [7:0] b);
    @(negedge CLOCK_50);
    cmd_byte = b;
    send = 1'b1;
    @(negedge CLOCK_50);
    send = 1'b0;
  endtask

  // Device: wait for request-to-send, clock out up to 10 bits sampling on rising edges, then ACK (or not).
  task automatic device_frame(input int pulses, input bit ack);
    int w = 0;
    while (!(ps2_clk_in === 1'b1 && ps2_dat_in === 1'b0) && w < 400) begin
      @(negedge CLOCK_50);
      w++;
    end
    if (w >= 400) return;
    got_bits.push_back(ps2_dat_in);
    repeat (HALF) @(negedge CLOCK_50);
    for (int i = 0; i < pulses && i < 10; i++) begin
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge CLOCK_50);
      got_bits.push_back(ps2_dat_in);
      dev_clk_low = 1'b0;
      repeat (HALF) @(negedge CLOCK_50);
    end
    if (pulses < 10) return;
    dev_dat_low = ack;
    repeat (5) @(negedge CLOCK_50);
    dev_clk_low = 1'b1;
    repeat (HALF) @(negedge CLOCK_50);
    dev_clk_low = 1'b0;
    dev_dat_low = 1'b0;
  endtask

  task automatic test_reset;
    #23;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL reset_done_error: got %b%b expected 00", done, error); end
    checks++; if (ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b0) begin errors++; $display("FAIL reset_oe: got %b%b expected 00", ps2_clk_oe, ps2_dat_oe); end
    @(negedge CLOCK_50);
    rst = 1'b1;
    repeat (3) @(negedge CLOCK_50);
  endtask

  task automatic test_ack;
    int inh_len = 0;
    int first_dat = 0;
    int n = 0;
    int idx = 0;
    bit e, g;
    push_frame(8'hED);
    exp_err.push_back(1'b0);
    do_send(8'hED);
    checks++; if (busy !== 1'b1 || ps2_clk_oe !== 1'b1) begin errors++; $display("FAIL ack_accept: got busy=%b clk_oe=%b expected 1 1", busy, ps2_clk_oe); end
    fork
      begin
        while (ps2_clk_oe === 1'b1 && inh_len < 200) begin
          inh_len++;
          if (ps2_dat_oe === 1'b1 && first_dat == 0) first_dat = inh_len;
          @(negedge CLOCK_50);
        end
      end
      device_frame(10, 1'b1);
    join
    checks++; if (inh_len != INH + 1) begin errors++; $display("FAIL ack_inhibit_len: got %0d expected %0d", inh_len, INH + 1); end
    checks++; if (first_dat != INH + 1) begin errors++; $display("FAIL ack_start_cycle: got %0d expected %0d", first_dat, INH + 1); end
    checks++; if (got_bits.size() != 11) begin errors++; $display("FAIL ack_frame_len: got %0d expected 11", got_bits.size()); end
    while (exp_bits.size() > 0) begin
      e = exp_bits.pop_front();
      g = (got_bits.size() > 0) ? got_bits.pop_front() : ~e;
      checks++; if (g !== e) begin errors++; $display("FAIL ack_bit%0d: got %b expected %b", idx, g, e); end
      idx++;
    end
    got_bits.delete();
    while (done !== 1'b1 && n < 300) begin @(negedge CLOCK_50); n++; end
    e = exp_err.pop_front();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL ack_done: got %b expected 1", done); end
    checks++; if (error !== e) begin errors++; $display("FAIL ack_error: got %b expected %b", error, e); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ack_busy_in_done: got %b expected 0", busy); end
    @(negedge CLOCK_50);
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL ack_after_done: got done=%b busy=%b expected 0 0", done, busy); end
    repeat (5) @(negedge CLOCK_50);
  endtask

  task automatic test_parity;
    int n = 0;
    int idx = 0;
    bit e, g;
    push_frame(8'h02);
    exp_err.push_back(1'b0);
    do_send(8'h02);
    device_frame(10, 1'b1);
    checks++; if (got_bits.size() != 11) begin errors++; $display("FAIL par_frame_len: got %0d expected 11", got_bits.size()); end
    while (exp_bits.size() > 0) begin
      e = exp_bits.pop_front();
      g = (got_bits.size() > 0) ? got_bits.pop_front() : ~e;
      checks++; if (g !== e) begin errors++; $display("FAIL par_bit%0d: got %b expected %b", idx, g, e); end
      idx++;
    end
    got_bits.delete();
    while (done !== 1'b1 && n < 300) begin @(negedge CLOCK_50); n++; end
    e = exp_err.pop_front();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL par_done: got %b expected 1", done); end
    checks++; if (error !== e) begin errors++; $display("FAIL par_error: got %b expected %b", error, e); end
    repeat (5) @(negedge CLOCK_50);
  endtask

  task automatic test_nack;
    int n = 0;
    bit e;
    push_frame(8'hA5);
    exp_err.push_back(1'b1);
    do_send(8'hA5);
    device_frame(10, 1'b0);
    exp_bits.delete();
    got_bits.delete();
    while (done !== 1'b1 && n < 300) begin @(negedge CLOCK_50); n++; end
    // A send in the done cycle must be ignored.
    cmd_byte = 8'h11;
    send = 1'b1;
    e = exp_err.pop_front();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL nack_done: got %b expected 1", done); end
    checks++; if (error !== e) begin errors++; $display("FAIL nack_error: got %b expected %b", error, e); end
    checks++; if (ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b0) begin errors++; $display("FAIL nack_oe: got %b%b expected 00", ps2_clk_oe, ps2_dat_oe); end
    @(negedge CLOCK_50);
    send = 1'b0;
    checks++; if (busy !== 1'b0 || ps2_clk_oe !== 1'b0) begin errors++; $display("FAIL done_cycle_send: got busy=%b clk_oe=%b expected 0 0", busy, ps2_clk_oe); end
    repeat (5) @(negedge CLOCK_50);
  endtask

  task automatic test_timeout;
    int w = 0;
    int n = 0;
    bit e;
    exp_err.push_back(1'b1);
    do_send(8'h3C);
    while (ps2_clk_oe === 1'b1 && w < 100) begin @(negedge CLOCK_50); w++; end
    while (done !== 1'b1 && n < 3000) begin
      @(posedge CLOCK_50);
      #1;
      n++;
    end
    e = exp_err.pop_front();
    checks++; if (n != TO) begin errors++; $display("FAIL timeout_cycles: got %0d expected %0d", n, TO); end
    checks++; if (error !== e || done !== 1'b1) begin errors++; $display("FAIL timeout_flags: got done=%b error=%b expected 1 %b", done, error, e); end
    checks++; if (ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b0) begin errors++; $display("FAIL timeout_oe: got %b%b expected 00", ps2_clk_oe, ps2_dat_oe); end
    repeat (5) @(negedge CLOCK_50);
  endtask

  task automatic test_reset_mid;
    int idx = 0;
    int n = 0;
    bit e, g;
    push_frame(8'h00);
    do_send(8'h00);
    device_frame(4, 1'b1);
    checks++; if (got_bits.size() != 5) begin errors++; $display("FAIL rmid_partial_len: got %0d expected 5", got_bits.size()); end
    while (got_bits.size() > 0) begin
      e = exp_bits.pop_front();
      g = got_bits.pop_front();
      checks++; if (g !== e) begin errors++; $display("FAIL rmid_bit%0d: got %b expected %b", idx, g, e); end
      idx++;
    end
    exp_bits.delete();
    checks++; if (busy !== 1'b1 || ps2_dat_oe !== 1'b1) begin errors++; $display("FAIL rmid_pre: got busy=%b dat_oe=%b expected 1 1", busy, ps2_dat_oe); end
    @(negedge CLOCK_50);
    #2 rst = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b expected 0", busy); end
    checks++; if (ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b0) begin errors++; $display("FAIL rmid_oe: got %b%b expected 00", ps2_clk_oe, ps2_dat_oe); end
    repeat (2) @(negedge CLOCK_50);
    rst = 1'b1;
    repeat (3) @(negedge CLOCK_50);
    idx = 0;
    push_frame(8'hFF);
    exp_err.push_back(1'b0);
    do_send(8'hFF);
    device_frame(10, 1'b1);
    checks++; if (got_bits.size() != 11) begin errors++; $display("FAIL rff_frame_len: got %0d expected 11", got_bits.size()); end
    while (exp_bits.size() > 0) begin
      e = exp_bits.pop_front();
      g = (got_bits.size() > 0) ? got_bits.pop_front() : ~e;
      checks++; if (g !== e) begin errors++; $display("FAIL rff_bit%0d: got %b expected %b", idx, g, e); end
      idx++;
    end
    got_bits.delete();
    while (done !== 1'b1 && n < 300) begin @(negedge CLOCK_50); n++; end
    e = exp_err.pop_front();
    checks++; if (done !== 1'b1 || error !== e) begin errors++; $display("FAIL rff_done: got done=%b error=%b expected 1 %b", done, error, e); end
    repeat (5) @(negedge CLOCK_50);
  endtask

  task automatic test_back_to_back;
    int base;
    int n = 0;
    int w = 0;
    int idx = 0;
    bit e, g;
    base = done_total;
    push_frame(8'hED);
    exp_err.push_back(1'b0);
    do_send(8'hED);
    fork
      device_frame(10, 1'b1);
      begin
        while (got_bits.size() < 4 && w < 2000) begin @(negedge CLOCK_50); w++; end
        cmd_byte = 8'h55;
        send = 1'b1;
        @(negedge CLOCK_50);
        send = 1'b0;
      end
    join
    checks++; if (got_bits.size() != 11) begin errors++; $display("FAIL busy_frame_len: got %0d expected 11", got_bits.size()); end
    while (exp_bits.size() > 0) begin
      e = exp_bits.pop_front();
      g = (got_bits.size() > 0) ? got_bits.pop_front() : ~e;
      checks++; if (g !== e) begin errors++; $display("FAIL busy_bit%0d: got %b expected %b", idx, g, e); end
      idx++;
    end
    got_bits.delete();
    while (done !== 1'b1 && n < 300) begin @(negedge CLOCK_50); n++; end
    e = exp_err.pop_front();
    checks++; if (done !== 1'b1 || error !== e) begin errors++; $display("FAIL busy_done: got done=%b error=%b expected 1 %b", done, error, e); end
    repeat (100) @(negedge CLOCK_50);
    checks++; if (done_total - base != 1) begin errors++; $display("FAIL busy_done_count: got %0d expected 1", done_total - base); end
    checks++; if (busy !== 1'b0 || ps2_clk_oe !== 1'b0) begin errors++; $display("FAIL busy_idle_after: got busy=%b clk_oe=%b expected 0 0", busy, ps2_clk_oe); end
  endtask

  initial begin
    test_reset;
    test_ack;
    test_parity;
    test_nack;
    test_timeout;
    test_reset_mid;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
